// File: rtl/load_store.sv
// load_store: RV32I load/store memory-access stage on a single whole-word RAM port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating them.
module load_store #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    localparam int unsigned DW  = 32;
    localparam int unsigned F3W = 3;
    localparam int unsigned CW  = 2;

    localparam logic [F3W-1:0] F3_B  = 3'b000;
    localparam logic [F3W-1:0] F3_H  = 3'b001;
    localparam logic [F3W-1:0] F3_W  = 3'b010;
    localparam logic [F3W-1:0] F3_BU = 3'b100;
    localparam logic [F3W-1:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           store_q, store_d;
    logic [F3W-1:0] f3_q, f3_d;
    logic [1:0]     off_q, off_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           bad_q, bad_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           we_q, we_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [DW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;

    logic           legal_c;
    logic           bad_c;
    logic [7:0]     lane_b_c;
    logic [15:0]    lane_h_c;
    logic [DW-1:0]  load_c;
    logic [DW-1:0]  merge_c;
`ifdef LSU_MISALIGN_TRAP_EN
    logic           misalign_c;
`endif

    // Classify the incoming request; only meaningful when start_i is sampled in IDLE.
    always_comb begin
        if (store_i) begin
            legal_c = funct3_i inside {F3_B, F3_H, F3_W};
        end else begin
            legal_c = funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_c = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        bad_c = !legal_c || misalign_c;
`else
        bad_c = !legal_c;
`endif
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    // Halfwords look only at off_q[1], so untrapped misaligned offsets truncate.
    always_comb begin
        case (off_q)
            2'd1:    lane_b_c = data_i[15:8];
            2'd2:    lane_b_c = data_i[23:16];
            2'd3:    lane_b_c = data_i[31:24];
            default: lane_b_c = data_i[7:0];
        endcase
        lane_h_c = off_q[1] ? data_i[31:16] : data_i[15:0];

        case (f3_q)
            F3_B:    load_c = {{24{lane_b_c[7]}}, lane_b_c};
            F3_H:    load_c = {{16{lane_h_c[15]}}, lane_h_c};
            F3_BU:   load_c = {24'd0, lane_b_c};
            F3_HU:   load_c = {16'd0, lane_h_c};
            default: load_c = data_i;
        endcase

        merge_c = data_i;
        if (f3_q == F3_B) begin
            case (off_q)
                2'd1:    merge_c[15:8]  = wdata_q[7:0];
                2'd2:    merge_c[23:16] = wdata_q[7:0];
                2'd3:    merge_c[31:24] = wdata_q[7:0];
                default: merge_c[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge_c[31:16] = wdata_q[15:0];
        end else begin
            merge_c[15:0] = wdata_q[15:0];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        f3_d    = f3_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    store_d = store_i;
                    f3_d    = funct3_i;
                    off_d   = addr_i[1:0];
                    wdata_d = wdata_i;
                    bad_d   = bad_c;
                    cnt_d   = '0;
                    if (bad_c) begin
                        state_d = S_DONE;
                    end else if (store_i && (funct3_i == F3_W)) begin
                        addr_d  = {addr_i[31:2], 2'b00};
                        data_d  = wdata_i;
                        state_d = S_WR;
                    end else begin
                        addr_d  = {addr_i[31:2], 2'b00};
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == CW'(READ_LATENCY - 1)) begin
                    state_d = S_CAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAP: begin
                if (store_q) begin
                    data_d  = merge_c;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_c;
                    state_d = S_DONE;
                end
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_DONE) && bad_d;
        we_d   = (state_d == S_WR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            store_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign we_o    = we_q;
    assign rdata_o = rdata_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule
